// File: rtl/len5_pkg.sv
// rtl/len5_pkg.sv - shared fetch-side types and constants
package len5_pkg;

   localparam int unsigned XLEN          = 64;
   localparam int unsigned ICACHE_INSTR  = 16;
   localparam int unsigned ICACHE_OFFSET = $clog2(ICACHE_INSTR);

   typedef logic [31:0] instr_t;

   localparam instr_t NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      E_I_ADDR_MISALIGNED   = 4'h0,
      E_I_ACCESS_FAULT      = 4'h1,
      E_ILLEGAL_INSTRUCTION = 4'h2,
      E_UNKNOWN             = 4'hF
   } except_code_t;

   typedef struct packed {
      logic [XLEN-1:0]            pc;
      instr_t [ICACHE_INSTR-1:0]  line;
   } icache_out_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      instr_t          instr;
      logic            except;
      except_code_t    ecode;
   } fetch_instr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } unpacker_state_t;

endpackage

// File: rtl/icache_line_unpacker_line_word_mux.sv
// rtl/icache_line_unpacker_line_word_mux.sv - selects one instruction word out of a cache line
module line_word_mux
   import len5_pkg::*;
#(
   parameter int unsigned LINE_INSTR = ICACHE_INSTR,
   parameter int unsigned IDX_W      = $clog2(LINE_INSTR)
) (
   input  instr_t [LINE_INSTR-1:0] line_i,
   input  logic   [IDX_W-1:0]      idx_i,
   output instr_t                  instr_o
);

   assign instr_o = line_i[idx_i];

endmodule

// File: rtl/icache_line_unpacker.sv
// rtl/icache_line_unpacker.sv - turns one I-cache line into a stream of single instructions
module icache_line_unpacker
   import len5_pkg::*;
#(
   parameter int unsigned LINE_INSTR = ICACHE_INSTR,
   parameter int unsigned IDX_W      = $clog2(LINE_INSTR)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            line_valid_i,
   output logic            line_ready_o,
   input  icache_out_t     line_i,
   input  logic            line_except_i,
   input  except_code_t    line_ecode_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output instr_t          instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            except_o,
   output except_code_t    except_code_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_INSTR - 1);

   unpacker_state_t           state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [XLEN-1:0]           base_pc_q, base_pc_d;
   logic [XLEN-1:0]           pc_q, pc_d;
   logic                      exc_q, exc_d;
   except_code_t              ecode_q, ecode_d;
   instr_t [LINE_INSTR-1:0]   line_q, line_d;

   logic                      last;
   logic                      accept;
   logic                      handshake;
   instr_t                    word;
   logic [XLEN-1:0]           word_off;
   fetch_instr_t              out_bundle;

   line_word_mux #(
      .LINE_INSTR (LINE_INSTR),
      .IDX_W      (IDX_W)
   ) u_word_mux (
      .line_i  (line_q),
      .idx_i   (idx_q),
      .instr_o (word)
   );

   // Exception lines are a single entry, so they always count as the last one.
   assign last         = exc_q | (idx_q == LAST_IDX);
   assign line_ready_o = ~flush_i & ((state_q == IDLE) |
                                     ((state_q == DRAIN) & last & instr_ready_i));
   assign accept       = line_valid_i & line_ready_o;
   assign handshake    = (state_q == DRAIN) & instr_ready_i & ~flush_i;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_pc_d = base_pc_q;
      pc_d      = pc_q;
      exc_d     = exc_q;
      ecode_d   = ecode_q;
      line_d    = line_q;
      if (flush_i) begin
         state_d = IDLE;
         idx_d   = '0;
         exc_d   = 1'b0;
      end else begin
         if (handshake) begin
            if (last) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         // Accept wins over the last-word return to IDLE, giving zero-bubble reloads.
         if (accept) begin
            state_d   = DRAIN;
            line_d    = line_i.line;
            pc_d      = line_i.pc;
            base_pc_d = {line_i.pc[XLEN-1:IDX_W+2], {(IDX_W+2){1'b0}}};
            idx_d     = line_i.pc[IDX_W+1:2];
            if (line_i.pc[1:0] != 2'b00) begin
               exc_d   = 1'b1;
               ecode_d = E_I_ADDR_MISALIGNED;
            end else if (line_except_i) begin
               exc_d   = 1'b1;
               ecode_d = line_ecode_i;
            end else begin
               exc_d   = 1'b0;
               ecode_d = E_UNKNOWN;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         base_pc_q <= '0;
         pc_q      <= '0;
         exc_q     <= 1'b0;
         ecode_q   <= E_UNKNOWN;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         base_pc_q <= base_pc_d;
         pc_q      <= pc_d;
         exc_q     <= exc_d;
         ecode_q   <= ecode_d;
         line_q    <= line_d;
      end
   end

   always_comb begin
      word_off                = '0;
      word_off[IDX_W+1:0]     = {idx_q, 2'b00};
      instr_valid_o           = (state_q == DRAIN) & ~flush_i;
      out_bundle.pc           = exc_q ? pc_q : (base_pc_q + word_off);
      out_bundle.instr        = (instr_valid_o & ~exc_q) ? word : NOP;
      out_bundle.except       = instr_valid_o & exc_q;
      out_bundle.ecode        = (instr_valid_o & exc_q) ? ecode_q : E_UNKNOWN;
   end

   assign instr_o       = out_bundle.instr;
   assign pc_o          = out_bundle.pc;
   assign except_o      = out_bundle.except;
   assign except_code_o = out_bundle.ecode;

endmodule

// File: tb/tb_icache_line_unpacker.sv
// tb/tb_icache_line_unpacker.sv - directed self-checking bench for icache_line_unpacker
module tb_icache_line_unpacker;
   import len5_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic            line_valid_i;
   logic            line_ready_o;
   icache_out_t     line_i;
   logic            line_except_i;
   except_code_t    line_ecode_i;
   logic            instr_valid_o;
   logic            instr_ready_i;
   instr_t          instr_o;
   logic [XLEN-1:0] pc_o;
   logic            except_o;
   except_code_t    except_code_o;

   int tests = 0;
   int fails = 0;

   always #10 clk_i = ~clk_i;

   icache_line_unpacker dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .line_valid_i  (line_valid_i),
      .line_ready_o  (line_ready_o),
      .line_i        (line_i),
      .line_except_i (line_except_i),
      .line_ecode_i  (line_ecode_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .except_o      (except_o),
      .except_code_o (except_code_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_line(input logic [63:0] pc, input logic [31:0] base);
      line_i.pc = pc;
      for (int k = 0; k < ICACHE_INSTR; k++) line_i.line[k] = base + 32'(k);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] ins, input logic [63:0] pc);
      chk({tag, ".valid"}, 64'(instr_valid_o), 64'd1);
      chk({tag, ".instr"}, 64'(instr_o), 64'(ins));
      chk({tag, ".pc"}, pc_o, pc);
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; line_valid_i = 1'b0; instr_ready_i = 1'b1;
      line_except_i = 1'b0; line_ecode_i = E_UNKNOWN; set_line(64'h0, 32'h0);
      tick(); tick();
      rst_i = 1'b0; #1;
      chk("rst.line_ready", 64'(line_ready_o), 64'd1);
      chk("rst.valid", 64'(instr_valid_o), 64'd0);
      chk("rst.instr", 64'(instr_o), 64'h13);
      chk("rst.pc", pc_o, 64'h0);
      chk("rst.except", 64'(except_o), 64'd0);
      chk("rst.ecode", 64'(except_code_o), 64'hF);

      // Full line from word 0
      set_line(64'h1000, 32'hA000_0000); line_valid_i = 1'b1; #1;
      chk("t1.accept_ready", 64'(line_ready_o), 64'd1);
      tick(); line_valid_i = 1'b0; #1;
      for (int k = 0; k < 16; k++) begin
         chk_out("t1.word", 32'hA000_0000 + 32'(k), 64'h1000 + 64'(4 * k));
         chk("t1.line_ready", 64'(line_ready_o), (k == 15) ? 64'd1 : 64'd0);
         tick();
      end
      chk("t1.done_valid", 64'(instr_valid_o), 64'd0);
      chk("t1.done_ready", 64'(line_ready_o), 64'd1);

      // Start near the end of the line
      set_line(64'h1038, 32'hB000_0000); line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; #1;
      chk_out("t2.w14", 32'hB000_000E, 64'h1038);
      tick();
      chk_out("t2.w15", 32'hB000_000F, 64'h103C);
      tick();
      chk("t2.idle_valid", 64'(instr_valid_o), 64'd0);

      // Back-to-back lines, no bubble
      set_line(64'h1030, 32'hC000_0000); line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; #1;
      for (int k = 12; k < 15; k++) begin
         chk_out("t3.a", 32'hC000_0000 + 32'(k), 64'h1000 + 64'(4 * k));
         tick();
      end
      chk_out("t3.a_last", 32'hC000_000F, 64'h103C);
      set_line(64'h203C, 32'hD000_0000); line_valid_i = 1'b1; #1;
      chk("t3.reload_ready", 64'(line_ready_o), 64'd1);
      tick(); line_valid_i = 1'b0; #1;
      chk_out("t3.b_first", 32'hD000_000F, 64'h203C);
      tick();
      chk("t3.b_done", 64'(instr_valid_o), 64'd0);

      // Stall at idx 3
      set_line(64'h3000, 32'hE000_0000); line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; tick(); tick(); tick();
      instr_ready_i = 1'b0; #1;
      for (int c = 0; c < 5; c++) begin
         chk_out("t4.hold", 32'hE000_0003, 64'h300C);
         chk("t4.hold_ready", 64'(line_ready_o), 64'd0);
         tick();
      end
      instr_ready_i = 1'b1; #1;
      chk_out("t4.resume", 32'hE000_0003, 64'h300C);
      tick();
      chk_out("t4.next", 32'hE000_0004, 64'h3010);
      tick(); tick(); tick();

      // Flush at idx 7 with a competing line
      chk_out("t5.idx7", 32'hE000_0007, 64'h301C);
      set_line(64'h4008, 32'hF000_0000); line_valid_i = 1'b1; flush_i = 1'b1; #1;
      chk("t5.flush_valid", 64'(instr_valid_o), 64'd0);
      chk("t5.flush_ready", 64'(line_ready_o), 64'd0);
      chk("t5.flush_instr", 64'(instr_o), 64'h13);
      tick(); flush_i = 1'b0; line_valid_i = 1'b0; #1;
      chk("t5.post_valid", 64'(instr_valid_o), 64'd0);
      chk("t5.post_ready", 64'(line_ready_o), 64'd1);
      line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; #1;
      chk_out("t5.clean", 32'hF000_0002, 64'h4008);
      chk("t5.clean_exc", 64'(except_o), 64'd0);

      // Reset mid-drain discards the line
      rst_i = 1'b1;
      tick(); rst_i = 1'b0; #1;
      chk("rst2.valid", 64'(instr_valid_o), 64'd0);
      chk("rst2.pc", pc_o, 64'h0);

      // Fetch fault
      set_line(64'h2004, 32'h1111_0000); line_except_i = 1'b1;
      line_ecode_i = E_I_ACCESS_FAULT; line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; line_except_i = 1'b0; #1;
      chk_out("t6.fault", 32'h0000_0013, 64'h2004);
      chk("t6.fault_exc", 64'(except_o), 64'd1);
      chk("t6.fault_code", 64'(except_code_o), 64'h1);
      chk("t6.fault_ready", 64'(line_ready_o), 64'd1);
      tick();
      chk("t6.fault_done", 64'(instr_valid_o), 64'd0);

      // Misaligned pc
      set_line(64'h2006, 32'h2222_0000); line_valid_i = 1'b1;
      tick(); line_valid_i = 1'b0; #1;
      chk_out("t6.mis", 32'h0000_0013, 64'h2006);
      chk("t6.mis_exc", 64'(except_o), 64'd1);
      chk("t6.mis_code", 64'(except_code_o), 64'h0);
      tick();
      chk("t6.mis_done", 64'(instr_valid_o), 64'd0);
      chk("t6.mis_done_exc", 64'(except_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
